// File: rtl/phy_regfile_read_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : phy_regfile_read_stage_pkg
// Brief    : Shared control types and default widths for the register-read stage.
// Revision : 1.0
// ============================================================================
package phy_regfile_read_stage_pkg;

    localparam int c_PHY_REG_W    = 6;
    localparam int c_VAL_W        = 32;
    localparam int c_NUM_WR_PORTS = 2;
    localparam int c_ADDR_W       = 32;
    localparam int c_IMM_W        = 32;

    typedef enum logic [1:0] {
        src_reg2 = 2'd0,
        src_imm  = 2'd1,
        src_pc   = 2'd2
    } alu_src_t;

    typedef enum logic [3:0] {
        add_op  = 4'd0,
        sub_op  = 4'd1,
        and_op  = 4'd2,
        or_op   = 4'd3,
        xor_op  = 4'd4,
        sll_op  = 4'd5,
        srl_op  = 4'd6,
        sra_op  = 4'd7,
        slt_op  = 4'd8,
        sltu_op = 4'd9
    } alu_op_t;

    typedef enum logic [1:0] {
        no_mem_op = 2'd0,
        load_op   = 2'd1,
        store_op  = 2'd2
    } memory_op_t;

    typedef struct packed {
        alu_src_t   alu_src;
        alu_op_t    alu_op;
        logic       is_branch_op;
        memory_op_t memory_op;
        logic       reg_wb;
    } control_t;

    localparam control_t c_CONTROL_RESET = '{
        alu_src:      src_reg2,
        alu_op:       add_op,
        is_branch_op: 1'b0,
        memory_op:    no_mem_op,
        reg_wb:       1'b0
    };

endpackage
`default_nettype wire

// File: rtl/phy_regfile_mem.sv
`default_nettype none
// ============================================================================
// Module   : phy_regfile_mem
// Brief    : Physical register array, NUM_WR_PORTS write ports, 2 async reads.
// Revision : 1.0
// ============================================================================
module phy_regfile_mem
    import phy_regfile_read_stage_pkg::*;
#(
    parameter int PHY_REG_W    = c_PHY_REG_W,
    parameter int VAL_W        = c_VAL_W,
    parameter int NUM_WR_PORTS = c_NUM_WR_PORTS
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_WR_PORTS-1:0]           wr_en,
    input  logic [NUM_WR_PORTS*PHY_REG_W-1:0] wr_reg,
    input  logic [NUM_WR_PORTS*VAL_W-1:0]     wr_val,
    input  logic [PHY_REG_W-1:0]              rd_reg1,
    input  logic [PHY_REG_W-1:0]              rd_reg2,
    output logic [VAL_W-1:0]                  rd_val1,
    output logic [VAL_W-1:0]                  rd_val2
);

    localparam int c_DEPTH = 1 << PHY_REG_W;

    logic [VAL_W-1:0] r_mem [c_DEPTH];

    // Ports are scanned in ascending order so the highest-index writer lands last.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_WR_PORTS; p++) begin
                if (wr_en[p] && (wr_reg[p*PHY_REG_W +: PHY_REG_W] != '0)) begin
                    r_mem[wr_reg[p*PHY_REG_W +: PHY_REG_W]] <= wr_val[p*VAL_W +: VAL_W];
                end
            end
        end
    end

    assign rd_val1 = (rd_reg1 == '0) ? '0 : r_mem[rd_reg1];
    assign rd_val2 = (rd_reg2 == '0) ? '0 : r_mem[rd_reg2];

endmodule
`default_nettype wire

// File: rtl/phy_regfile_read_stage.sv
`default_nettype none
// ============================================================================
// Module   : phy_regfile_read_stage
// Brief    : Register-read stage with valid/ready output slot and flush.
//            PHY_RF_BYPASS_EN enables commit-to-read bypass and stall refresh.
// Revision : 1.0
// ============================================================================
module phy_regfile_read_stage
    import phy_regfile_read_stage_pkg::*;
#(
    parameter int PHY_REG_W    = c_PHY_REG_W,
    parameter int VAL_W        = c_VAL_W,
    parameter int NUM_WR_PORTS = c_NUM_WR_PORTS,
    parameter int ADDR_W       = c_ADDR_W,
    parameter int IMM_W        = c_IMM_W
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [PHY_REG_W-1:0]              src_phy_reg1_in,
    input  logic [PHY_REG_W-1:0]              src_phy_reg2_in,
    input  logic [PHY_REG_W-1:0]              dst_phy_reg_in,
    input  control_t                          control_in,
    input  logic [ADDR_W-1:0]                 pc_in,
    input  logic [IMM_W-1:0]                  generated_immediate_in,
    input  logic [NUM_WR_PORTS-1:0]           commit_wr_en,
    input  logic [NUM_WR_PORTS*PHY_REG_W-1:0] commit_wr_reg,
    input  logic [NUM_WR_PORTS*VAL_W-1:0]     commit_wr_val,
    input  logic                              flush,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [VAL_W-1:0]                  src_val1,
    output logic [VAL_W-1:0]                  src_val2,
    output logic [PHY_REG_W-1:0]              src_phy_reg1_out,
    output logic [PHY_REG_W-1:0]              src_phy_reg2_out,
    output logic [PHY_REG_W-1:0]              dst_phy_reg_out,
    output control_t                          control_out,
    output logic [ADDR_W-1:0]                 pc_out,
    output logic [IMM_W-1:0]                  generated_immediate_out
);

    logic [VAL_W-1:0]     w_rf_val1;
    logic [VAL_W-1:0]     w_rf_val2;
    logic [VAL_W-1:0]     w_cap_val1;
    logic [VAL_W-1:0]     w_cap_val2;
    logic [VAL_W-1:0]     w_hold_val1;
    logic [VAL_W-1:0]     w_hold_val2;
    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_fire;

    logic                 r_out_valid;
    logic [VAL_W-1:0]     r_src_val1;
    logic [VAL_W-1:0]     r_src_val2;
    logic [PHY_REG_W-1:0] r_src_phy_reg1;
    logic [PHY_REG_W-1:0] r_src_phy_reg2;
    logic [PHY_REG_W-1:0] r_dst_phy_reg;
    control_t             r_control;
    logic [ADDR_W-1:0]    r_pc;
    logic [IMM_W-1:0]     r_imm;

    phy_regfile_mem #(
        .PHY_REG_W    (PHY_REG_W),
        .VAL_W        (VAL_W),
        .NUM_WR_PORTS (NUM_WR_PORTS)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (commit_wr_en),
        .wr_reg  (commit_wr_reg),
        .wr_val  (commit_wr_val),
        .rd_reg1 (src_phy_reg1_in),
        .rd_reg2 (src_phy_reg2_in),
        .rd_val1 (w_rf_val1),
        .rd_val2 (w_rf_val2)
    );

`ifdef PHY_RF_BYPASS_EN
    // Returns the newest same-cycle commit value for tag, else the fallback.
    function automatic logic [VAL_W-1:0] f_bypass(
        input logic [PHY_REG_W-1:0] tag,
        input logic [VAL_W-1:0]     fallback
    );
        f_bypass = fallback;
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
            if (commit_wr_en[p] && (tag != '0) &&
                (commit_wr_reg[p*PHY_REG_W +: PHY_REG_W] == tag)) begin
                f_bypass = commit_wr_val[p*VAL_W +: VAL_W];
            end
        end
    endfunction

    assign w_cap_val1  = f_bypass(src_phy_reg1_in, w_rf_val1);
    assign w_cap_val2  = f_bypass(src_phy_reg2_in, w_rf_val2);
    assign w_hold_val1 = f_bypass(r_src_phy_reg1, r_src_val1);
    assign w_hold_val2 = f_bypass(r_src_phy_reg2, r_src_val2);
`else
    assign w_cap_val1  = w_rf_val1;
    assign w_cap_val2  = w_rf_val2;
    assign w_hold_val1 = r_src_val1;
    assign w_hold_val2 = r_src_val2;
`endif

    assign w_in_ready = !r_out_valid || out_ready;
    assign w_accept   = in_valid && w_in_ready && !flush;
    assign w_fire     = r_out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid    <= 1'b0;
            r_src_val1     <= '0;
            r_src_val2     <= '0;
            r_src_phy_reg1 <= '0;
            r_src_phy_reg2 <= '0;
            r_dst_phy_reg  <= '0;
            r_control      <= c_CONTROL_RESET;
            r_pc           <= '0;
            r_imm          <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid    <= 1'b1;
            r_src_val1     <= w_cap_val1;
            r_src_val2     <= w_cap_val2;
            r_src_phy_reg1 <= src_phy_reg1_in;
            r_src_phy_reg2 <= src_phy_reg2_in;
            r_dst_phy_reg  <= dst_phy_reg_in;
            r_control      <= control_in;
            r_pc           <= pc_in;
            r_imm          <= generated_immediate_in;
        end else if (w_fire) begin
            r_out_valid <= 1'b0;
        end else if (r_out_valid) begin
            // Stalled: keep operands current with commits to the held tags.
            r_src_val1 <= w_hold_val1;
            r_src_val2 <= w_hold_val2;
        end
    end

    assign in_ready                = w_in_ready;
    assign out_valid               = r_out_valid;
    assign src_val1                = r_src_val1;
    assign src_val2                = r_src_val2;
    assign src_phy_reg1_out        = r_src_phy_reg1;
    assign src_phy_reg2_out        = r_src_phy_reg2;
    assign dst_phy_reg_out         = r_dst_phy_reg;
    assign control_out             = r_control;
    assign pc_out                  = r_pc;
    assign generated_immediate_out = r_imm;

endmodule
`default_nettype wire

// File: tb/tb_phy_regfile_read_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_phy_regfile_read_stage
// Brief    : Directed self-checking bench with an in-order expected-output queue.
// Revision : 1.0
// ============================================================================
module tb_phy_regfile_read_stage;
    import phy_regfile_read_stage_pkg::*;

`ifdef PHY_RF_BYPASS_EN
    localparam bit c_BYP = 1'b1;
`else
    localparam bit c_BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  src_phy_reg1_in, src_phy_reg2_in, dst_phy_reg_in;
    control_t    control_in;
    logic [31:0] pc_in, generated_immediate_in;
    logic [1:0]  commit_wr_en;
    logic [11:0] commit_wr_reg;
    logic [63:0] commit_wr_val;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] src_val1, src_val2;
    logic [5:0]  src_phy_reg1_out, src_phy_reg2_out, dst_phy_reg_out;
    control_t    control_out;
    logic [31:0] pc_out, generated_immediate_out;

    typedef struct {
        logic [31:0] v1;
        logic [31:0] v2;
        logic [5:0]  t1;
        logic [5:0]  t2;
        logic [5:0]  d;
        control_t    c;
        logic [31:0] pc;
        logic [31:0] imm;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    control_t c_alt;

    phy_regfile_read_stage dut (
        .clk                     (clk),
        .reset                   (reset),
        .in_valid                (in_valid),
        .in_ready                (in_ready),
        .src_phy_reg1_in         (src_phy_reg1_in),
        .src_phy_reg2_in         (src_phy_reg2_in),
        .dst_phy_reg_in          (dst_phy_reg_in),
        .control_in              (control_in),
        .pc_in                   (pc_in),
        .generated_immediate_in  (generated_immediate_in),
        .commit_wr_en            (commit_wr_en),
        .commit_wr_reg           (commit_wr_reg),
        .commit_wr_val           (commit_wr_val),
        .flush                   (flush),
        .out_valid               (out_valid),
        .out_ready               (out_ready),
        .src_val1                (src_val1),
        .src_val2                (src_val2),
        .src_phy_reg1_out        (src_phy_reg1_out),
        .src_phy_reg2_out        (src_phy_reg2_out),
        .dst_phy_reg_out         (dst_phy_reg_out),
        .control_out             (control_out),
        .pc_out                  (pc_out),
        .generated_immediate_out (generated_immediate_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compares the slot against the oldest expectation when it fires, then advances a clock.
    task automatic tick();
        exp_t e;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("fire_unexpected", 64'(out_valid), 64'(0));
            end else begin
                e = sb.pop_front();
                check("fire_val1", 64'(src_val1), 64'(e.v1));
                check("fire_val2", 64'(src_val2), 64'(e.v2));
                check("fire_tags", 64'({src_phy_reg1_out, src_phy_reg2_out, dst_phy_reg_out}),
                      64'({e.t1, e.t2, e.d}));
                check("fire_ctrl", 64'(control_out), 64'(e.c));
                check("fire_pc_imm", {pc_out, generated_immediate_out}, {e.pc, e.imm});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input int p, input logic [5:0] tag, input logic [31:0] v);
        commit_wr_en[p]           = 1'b1;
        commit_wr_reg[p*6 +: 6]   = tag;
        commit_wr_val[p*32 +: 32] = v;
    endtask

    task automatic clear_commits();
        commit_wr_en  = '0;
        commit_wr_reg = '0;
        commit_wr_val = '0;
    endtask

    task automatic issue(input logic [5:0] t1, input logic [5:0] t2, input logic [5:0] d,
                         input control_t c, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] e1, input logic [31:0] e2, input bit push);
        exp_t e;
        in_valid               = 1'b1;
        src_phy_reg1_in        = t1;
        src_phy_reg2_in        = t2;
        dst_phy_reg_in         = d;
        control_in             = c;
        pc_in                  = pc;
        generated_immediate_in = imm;
        if (push) begin
            e = '{v1: e1, v2: e2, t1: t1, t2: t2, d: d, c: c, pc: pc, imm: imm};
            sb.push_back(e);
        end
    endtask

    initial begin
        c_alt = '{alu_src: src_imm, alu_op: sub_op, is_branch_op: 1'b1,
                  memory_op: load_op, reg_wb: 1'b1};
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        src_phy_reg1_in = '0; src_phy_reg2_in = '0; dst_phy_reg_in = '0;
        control_in = c_CONTROL_RESET; pc_in = '0; generated_immediate_in = '0;
        clear_commits();
        tick();
        tick();
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_vals", {src_val1, src_val2}, 64'(0));
        check("rst_ctrl", 64'(control_out), 64'(10'b00_0000_0_00_0));
        check("rst_pc_imm", {pc_out, generated_immediate_out}, 64'(0));
        reset = 1'b0;

        // First read of p5 after reset
        out_ready = 1'b1;
        issue(6'd5, 6'd0, 6'd1, c_CONTROL_RESET, 32'h100, 32'h10, 32'h0, 32'h0, 1'b1);
        tick();
        in_valid = 1'b0;
        check("first_valid", 64'(out_valid), 64'(1));
        check("first_val1", 64'(src_val1), 64'(0));
        check("first_ctrl", 64'(control_out), 64'(10'b00_0000_0_00_0));
        check("first_in_ready", 64'(in_ready), 64'(1));
        tick();

        // Commit then read next cycle
        commit(0, 6'd5, 32'h1234);
        tick();
        clear_commits();
        issue(6'd5, 6'd0, 6'd2, c_alt, 32'h104, 32'h20, 32'h1234, 32'h0, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();

        // Same-cycle commit and read
        commit(0, 6'd6, 32'h4321);
        issue(6'd6, 6'd5, 6'd3, c_alt, 32'h108, 32'h30,
              c_BYP ? 32'h4321 : 32'h0, 32'h1234, 1'b1);
        tick();
        clear_commits();
        in_valid = 1'b0;
        tick();
        issue(6'd6, 6'd6, 6'd3, c_alt, 32'h10c, 32'h34, 32'h4321, 32'h4321, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();

        // Write-port priority and p0 immunity
        commit(0, 6'd7, 32'hAAAA);
        commit(1, 6'd7, 32'hBBBB);
        tick();
        clear_commits();
        commit(0, 6'd0, 32'hFFFF);
        tick();
        clear_commits();
        issue(6'd7, 6'd0, 6'd4, c_alt, 32'h110, 32'h40, 32'hBBBB, 32'h0, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();

        // Stall with refresh of a held source
        out_ready = 1'b0;
        issue(6'd5, 6'd9, 6'd8, c_alt, 32'h120, 32'h50, 32'h1234, 32'h0, 1'b1);
        tick();
        in_valid = 1'b0;
        check("stall_val2_before", 64'(src_val2), 64'(0));
        commit(1, 6'd9, 32'h55);
        tick();
        clear_commits();
        sb[0].v2 = c_BYP ? 32'h55 : 32'h0;
        check("stall_val2_after", 64'(src_val2), 64'(c_BYP ? 32'h55 : 32'h0));
        check("stall_valid", 64'(out_valid), 64'(1));
        check("stall_in_ready", 64'(in_ready), 64'(0));
        check("stall_stable", {src_val1, pc_out}, {32'h1234, 32'h120});
        check("stall_tags", 64'({src_phy_reg1_out, src_phy_reg2_out, dst_phy_reg_out}),
              64'({6'd5, 6'd9, 6'd8}));
        out_ready = 1'b1;
        tick();

        // Back-to-back, four instructions
        for (int i = 0; i < 4; i++) begin
            issue(6'd5, 6'd7, 6'(10 + i), (i % 2 == 0) ? c_alt : c_CONTROL_RESET,
                  32'h200 + 32'(4 * i), 32'(i), 32'h1234, 32'hBBBB, 1'b1);
            tick();
            check("b2b_valid", 64'(out_valid), 64'(1));
            check("b2b_in_ready", 64'(in_ready), 64'(1));
        end
        in_valid = 1'b0;
        tick();
        check("b2b_drained", 64'(out_valid), 64'(0));

        // Flush while stalled; commit during flush still lands
        out_ready = 1'b0;
        issue(6'd5, 6'd0, 6'd20, c_alt, 32'h300, 32'h60, 32'h1234, 32'h0, 1'b1);
        tick();
        issue(6'd7, 6'd7, 6'd21, c_alt, 32'h304, 32'h64, 32'h0, 32'h0, 1'b0);
        flush = 1'b1;
        commit(0, 6'd11, 32'h77);
        tick();
        void'(sb.pop_back());
        check("flush_valid", 64'(out_valid), 64'(0));
        flush = 1'b0;
        in_valid = 1'b0;
        clear_commits();
        tick();
        check("flush_no_accept", 64'(out_valid), 64'(0));
        out_ready = 1'b1;
        issue(6'd11, 6'd0, 6'd22, c_alt, 32'h308, 32'h68, 32'h77, 32'h0, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();

        // Reset mid-stall clears slot and array
        out_ready = 1'b0;
        issue(6'd11, 6'd5, 6'd23, c_alt, 32'h400, 32'h70, 32'h77, 32'h1234, 1'b1);
        tick();
        in_valid = 1'b0;
        check("pre_reset_valid", 64'(out_valid), 64'(1));
        reset = 1'b1;
        tick();
        void'(sb.pop_back());
        reset = 1'b0;
        check("midrst_valid", 64'(out_valid), 64'(0));
        check("midrst_vals", {src_val1, src_val2}, 64'(0));
        check("midrst_pc_imm", {pc_out, generated_immediate_out}, 64'(0));
        check("midrst_tags_ctrl", 64'({src_phy_reg1_out, src_phy_reg2_out, dst_phy_reg_out,
              control_out}), 64'(0));
        out_ready = 1'b1;
        issue(6'd11, 6'd5, 6'd24, c_alt, 32'h404, 32'h74, 32'h0, 32'h0, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();

        check("sb_drain", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
